// File: rtl/mem_router.sv
// CPU-side memory router: decodes word addresses into an on-chip SRAM window
// or an external controller window, sequences each access and returns a
// single-cycle completion (with error flag on external timeout).
module mem_router #(
    parameter int unsigned ADDR_W   = 30,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SRAM_AW  = 12,
    parameter int unsigned EXT_AW   = 27,
    parameter int unsigned SRAM_LAT = 1,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    // CPU side
    input  logic                i_cpu_req,
    input  logic                i_cpu_we,
    input  logic [ADDR_W-1:0]   i_cpu_addr,
    input  logic [DATA_W-1:0]   i_cpu_wdata,
    input  logic [DATA_W/8-1:0] i_cpu_be,
    output logic                o_cpu_ready,
    output logic                o_cpu_done,
    output logic [DATA_W-1:0]   o_cpu_rdata,
    output logic                o_cpu_err,
    // SRAM side
    output logic [SRAM_AW-1:0]  o_sram_addr,
    output logic [DATA_W-1:0]   o_sram_wdata,
    output logic [DATA_W/8-1:0] o_sram_be,
    output logic                o_sram_wren,
    input  logic [DATA_W-1:0]   i_sram_q,
    // External controller side
    output logic [EXT_AW-1:0]   o_ext_addr,
    output logic [DATA_W-1:0]   o_ext_wdata,
    output logic [DATA_W/8-1:0] o_ext_be,
    output logic                o_ext_read_req,
    output logic                o_ext_write_req,
    input  logic                i_ext_wait,
    input  logic [DATA_W-1:0]   i_ext_rdata,
    input  logic                i_ext_rdata_valid
);

    localparam int unsigned BeW  = DATA_W / 8;
    localparam int unsigned LatW = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;
    localparam int unsigned ToW  = $clog2(TIMEOUT + 1);

    // First external word address, full width and truncated to the external bus
    localparam logic [ADDR_W-1:0] SramWords = ADDR_W'(2 ** SRAM_AW);
    localparam logic [EXT_AW-1:0] ExtBase   = EXT_AW'(2 ** SRAM_AW);

    typedef enum logic [2:0] {
        StIdle,
        StSramWr,
        StSramRd,
        StExtCmd,
        StExtRd,
        StResp
    } state_e;

    state_e              r_state;
    state_e              w_state_d;

    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [BeW-1:0]      r_be;
    logic [SRAM_AW-1:0]  r_sram_addr;
    logic [EXT_AW-1:0]   r_ext_addr;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [LatW-1:0]     r_lat;
    logic [ToW-1:0]      r_to_cnt;

    logic                w_is_ext;
    logic [EXT_AW-1:0]   w_ext_addr;
    logic                w_accept;
    logic                w_sram_cap;
    logic                w_ext_cap;
    logic                w_timeout;
    logic                w_in_ext;
    logic                w_to_hit;

    // Low bits of a true subtraction, so the SRAM window never aliases externally
    assign w_is_ext   = (i_cpu_addr >= SramWords);
    assign w_ext_addr = i_cpu_addr[EXT_AW-1:0] - ExtBase;

    assign w_in_ext = (r_state == StExtCmd) || (r_state == StExtRd);
    // >= keeps a late command acceptance from escaping the timeout in StExtRd
    assign w_to_hit = (r_to_cnt >= ToW'(TIMEOUT - 1));

    // Next-state decode and datapath strobes
    always_comb begin
        w_state_d  = r_state;
        w_accept   = 1'b0;
        w_sram_cap = 1'b0;
        w_ext_cap  = 1'b0;
        w_timeout  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_cpu_req) begin
                    w_accept = 1'b1;
                    if (w_is_ext)      w_state_d = StExtCmd;
                    else if (i_cpu_we) w_state_d = StSramWr;
                    else               w_state_d = StSramRd;
                end
            end
            StSramWr: w_state_d = StIdle;
            StSramRd: begin
                if (r_lat == LatW'(SRAM_LAT - 1)) begin
                    w_sram_cap = 1'b1;
                    w_state_d  = StResp;
                end
            end
            StExtCmd: begin
                if (!i_ext_wait) begin
                    w_state_d = r_we ? StResp : StExtRd;
                end else if (w_to_hit) begin
                    w_timeout = 1'b1;
                    w_state_d = StResp;
                end
            end
            StExtRd: begin
                if (i_ext_rdata_valid) begin
                    w_ext_cap = 1'b1;
                    w_state_d = StResp;
                end else if (w_to_hit) begin
                    w_timeout = 1'b1;
                    w_state_d = StResp;
                end
            end
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_state_d;
    end

    // Request capture, counters and response data
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_sram_addr <= '0;
            r_ext_addr  <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_lat       <= '0;
            r_to_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_we     <= i_cpu_we;
                r_wdata  <= i_cpu_wdata;
                r_be     <= i_cpu_be;
                r_err    <= 1'b0;
                r_lat    <= '0;
                r_to_cnt <= '0;
                if (w_is_ext) r_ext_addr  <= w_ext_addr;
                else          r_sram_addr <= i_cpu_addr[SRAM_AW-1:0];
            end
            if (r_state == StSramRd) r_lat <= r_lat + LatW'(1);
            if (w_in_ext)            r_to_cnt <= r_to_cnt + ToW'(1);
            if (w_sram_cap)          r_rdata <= i_sram_q;
            if (w_ext_cap)           r_rdata <= i_ext_rdata;
            if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    assign o_cpu_ready     = (r_state == StIdle);
    assign o_cpu_done      = (r_state == StSramWr) || (r_state == StResp);
    assign o_cpu_err       = (r_state == StResp) && r_err;
    assign o_cpu_rdata     = r_rdata;

    assign o_sram_addr     = r_sram_addr;
    assign o_sram_wdata    = r_wdata;
    assign o_sram_be       = r_be;
    assign o_sram_wren     = (r_state == StSramWr);

    assign o_ext_addr      = r_ext_addr;
    assign o_ext_wdata     = r_wdata;
    assign o_ext_be        = r_be;
    assign o_ext_read_req  = (r_state == StExtCmd) && !r_we;
    assign o_ext_write_req = (r_state == StExtCmd) && r_we;

endmodule

// File: doc/mem_router.md
# mem_router

Parametrised CPU-side memory router: decodes each word address into an on-chip SRAM window or an external (LPDDR2 controller) window. Runs a registered request/response handshake towards the CPU, handles SRAM read latency and external wait-request/read-valid flow control, and aborts hung external accesses with an error response. Sits between the CPU's memory stage and both memory back-ends; the SRAM macro and the LPDDR2 controller are instantiated outside.

## Interface
- ADDR_W, 30: CPU word-address width.
- DATA_W, 32: data width, multiple of 8.
- SRAM_AW, 12: SRAM word-address width; SRAM window is words 0 .. 2**SRAM_AW-1.
- EXT_AW, 27: external word-address width.
- SRAM_LAT, 1: SRAM read latency in cycles (1..4).
- TIMEOUT, 255: external-access timeout in cycles (≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request valid.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_be  in  DATA_W/8  byte enables.
- cpu_ready  out  1  router idle; request accepted when cpu_req && cpu_ready.
- cpu_done  out  1  one-cycle completion pulse (reads and writes).
- cpu_rdata  out  DATA_W  read data; valid with cpu_done, held until the next read completes.
- cpu_err  out  1  with cpu_done: access timed out.
- sram_addr  out  SRAM_AW,  sram_wdata  out  DATA_W,  sram_be  out  DATA_W/8,  sram_wren  out  1,  sram_q  in  DATA_W.
- ext_addr  out  EXT_AW,  ext_wdata  out  DATA_W,  ext_be  out  DATA_W/8.
- ext_read_req  out  1,  ext_write_req  out  1.
- ext_wait  in  1  controller not accepting the command this cycle.
- ext_rdata  in  DATA_W,  ext_rdata_valid  in  1.

## Operation
- Decode: is_ext = cpu_addr ≥ 2**SRAM_AW. ext_addr = (cpu_addr − 2**SRAM_AW) truncated to EXT_AW (true subtraction, no aliasing of SRAM window). sram_addr = cpu_addr[SRAM_AW-1:0].
- On acceptance, addr/we/wdata/be/is_ext are registered; all back-end outputs are driven from registers only.
- FSM states: IDLE, SRAM_WR, SRAM_RD, EXT_CMD, EXT_RD, RESP.
- IDLE: cpu_ready=1. Accept → SRAM_WR / SRAM_RD / EXT_CMD by is_ext and we.
- SRAM_WR: sram_wren=1 one cycle, cpu_done=1 same cycle → IDLE.
- SRAM_RD: lat counter runs SRAM_LAT cycles; sram_q captured into cpu_rdata on final cycle → RESP.
- EXT_CMD: ext_read_req or ext_write_req held high with stable addr/data/be until a cycle with ext_wait=0. Write → RESP. Read → EXT_RD.
- EXT_RD: wait for ext_rdata_valid; capture ext_rdata → RESP.
- RESP: cpu_done=1 one cycle → IDLE.
- Timeout: counter cleared on acceptance, increments every cycle in EXT_CMD/EXT_RD. Reaching TIMEOUT: drop requests, cpu_rdata=0, cpu_err=1 with cpu_done in RESP.
- ext_rdata_valid outside EXT_RD (late data after timeout): ignored.
- cpu_req while cpu_ready=0: ignored; CPU holds request.
- ext_read_req and ext_write_req never both high; both low outside EXT_CMD.
- sram_wren high only in SRAM_WR.

## Timing
- Reset (rst=0, async): state IDLE, cpu_ready=1, cpu_done=0, cpu_err=0, cpu_rdata=0, sram_wren=0, ext_*_req=0, all address/data outputs 0, counters 0. Reset mid-transaction abandons it; no completion pulse.
- Accept in cycle T. SRAM write: sram_wren and cpu_done at T+1, cpu_ready at T+2.
- SRAM read: sram_addr valid from T+1; cpu_done at T+1+SRAM_LAT (SRAM_LAT=1 → T+2).
- Ext write: req from T+1; first ext_wait=0 cycle W; cpu_done at W+1.
- Ext read: command accepted W; ext_rdata_valid at V>W; cpu_done at V+1.
- Timeout: fires on TIMEOUT-th counted cycle; cpu_done/cpu_err the cycle after.
- Back-to-back: minimum 2 cycles between acceptances.

## Test plan
- Reset then SRAM write addr 0x005, data 0xA5A5A5A5, be 0xF; read back -> sram_wren pulse at T+1, read cpu_done at T+2, cpu_rdata=0xA5A5A5A5, cpu_err=0.
- Boundary decode: addr 0xFFF -> SRAM, sram_addr=0xFFF; addr 0x1000 -> ext_addr=0x0000000; addr 0x1234 -> ext_addr=0x234.
- Ext write with ext_wait high 5 cycles -> ext_write_req held 6 cycles, addr/data stable, cpu_done 1 cycle after ext_wait falls.
- Ext read, ext_wait=0, ext_rdata_valid 3 cycles later with 0xDEADBEEF -> cpu_rdata=0xDEADBEEF, single cpu_done.
- Ext read never answered, TIMEOUT=16 -> req dropped, cpu_done+cpu_err, cpu_rdata=0; late ext_rdata_valid ignored; next SRAM access normal.
- rst low during EXT_CMD -> outputs return to reset values immediately, no cpu_done; post-reset accesses correct.
